// File: rtl/fp16_unpack.sv
// fp16_unpack: binary16 operand decoder for the SD4 MAC front end.
// Two-stage valid/ready pipeline: S1 captures and classifies the word and
// counts mantissa leading zeros; S2 applies the normalising shift and
// drives the registered outputs. Subnormals are pre-normalised, so
// downstream stages see a single operand format.
// Build option: define SD4_UNPACK_DAZ_EN to flush subnormals to signed zero.
// In that build the leading-zero counter is not built.
module fp16_unpack #(
  parameter int EXP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp_out,
  output logic [10:0]      sig_out,
  output logic             is_zero,
  output logic             is_sub,
  output logic             is_inf,
  output logic             is_nan
);

  logic       s2_adv;
  logic       accept;
  logic [4:0] in_e;
  logic [9:0] in_m;
  logic       c_zero, c_sub, c_inf, c_nan;

  logic       s1_valid;
  logic       s1_sign;
  logic [4:0] s1_e;
  logic [9:0] s1_m;
  logic       s1_zero, s1_sub, s1_inf, s1_nan;

  logic [EXP_W-1:0] d_exp;
  logic [10:0]      d_sig;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  assign in_e = in_data[14:10];
  assign in_m = in_data[9:0];

`ifdef SD4_UNPACK_DAZ_EN
  // Subnormals collapse onto signed zero, so the whole E==0 band is zero.
  assign c_zero = (in_e == 5'd0);
  assign c_sub  = 1'b0;
`else
  logic [3:0] in_lz;
  logic [3:0] s1_lz;
  logic [EXP_W-1:0] lz_ext;
  logic [10:0]      sub_sig;

  assign c_zero = (in_e == 5'd0) && (in_m == 10'd0);
  assign c_sub  = (in_e == 5'd0) && (in_m != 10'd0);

  // Leading-zero count of the mantissa; only meaningful for a subnormal.
  always_comb begin
    logic found;
    in_lz = 4'd0;
    found = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (!found && in_m[i]) begin
        in_lz = 4'(9 - i);
        found = 1'b1;
      end
    end
  end

  // Keep the shift count alongside the S1 word.
  always_ff @(posedge clk) begin
    if (!rst) s1_lz <= 4'd0;
    else if (accept) s1_lz <= in_lz;
  end

  // Shifting {M,0} left by p puts the leading one in bit 10.
  assign lz_ext  = {{(EXP_W-4){1'b0}}, s1_lz};
  assign sub_sig = {s1_m, 1'b0} << s1_lz;
`endif

  assign c_inf = (in_e == 5'd31) && (in_m == 10'd0);
  assign c_nan = (in_e == 5'd31) && (in_m != 10'd0);

  // S1: capture and classify the incoming word; empties when S2 takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= 5'd0;
      s1_m     <= 10'd0;
      s1_zero  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_sign <= in_data[15];
        s1_e    <= in_e;
        s1_m    <= in_m;
        s1_zero <= c_zero;
        s1_sub  <= c_sub;
        s1_inf  <= c_inf;
        s1_nan  <= c_nan;
      end
    end
  end

  // Decode: normal, inf and NaN all share exp=E, sig={1,M}.
  always_comb begin
    d_exp = {{(EXP_W-5){1'b0}}, s1_e};
    d_sig = {1'b1, s1_m};
    if (s1_zero) begin
      d_exp = '0;
      d_sig = 11'd0;
    end
`ifndef SD4_UNPACK_DAZ_EN
    else if (s1_sub) begin
      d_exp = ~lz_ext + 1'b1;
      d_sig = sub_sig;
    end
`endif
  end

  // S2: output register; holds everything while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      sign      <= 1'b0;
      exp_out   <= '0;
      sig_out   <= 11'd0;
      is_zero   <= 1'b0;
      is_sub    <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign    <= s1_sign;
        exp_out <= d_exp;
        sig_out <= d_sig;
        is_zero <= s1_zero;
        is_sub  <= s1_sub;
        is_inf  <= s1_inf;
        is_nan  <= s1_nan;
      end
    end
  end

endmodule

// File: tb/tb_fp16_unpack.sv
// Bench for fp16_unpack: directed cases plus randomised traffic, all results
// checked against a value-level binary16 decode model through a scoreboard.
module tb_fp16_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [6:0]  exp_out;
  logic [10:0] sig_out;
  logic        is_zero, is_sub, is_inf, is_nan;

  int n_vec = 0;
  int n_err = 0;

  logic [22:0] exp_q[$];
  logic [6:0]  emit_log[$];
  logic [22:0] held;
  logic        held_v = 1'b0;

  fp16_unpack #(.EXP_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp_out(exp_out), .sig_out(sig_out),
    .is_zero(is_zero), .is_sub(is_sub), .is_inf(is_inf), .is_nan(is_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [22:0] pack_out();
    return {sign, is_zero, is_sub, is_inf, is_nan, exp_out, sig_out};
  endfunction

  // Value-level model: the significand is scaled up until it reaches 1.0
  // (1024 in units of 2^-10), lowering the exponent once per doubling.
  function automatic logic [22:0] model(input logic [15:0] w);
    int e, sig;
    logic s;
    logic [3:0] f;
    logic [31:0] eb, sb;
    s   = w[15];
    e   = int'(w[14:10]);
    sig = int'(w[9:0]);
    if (e == 31) begin
      f   = (sig == 0) ? 4'b0010 : 4'b0001;
      sig = sig + 1024;
    end else if (e == 0 && sig == 0) begin
      f = 4'b1000;
    end else if (e == 0) begin
`ifdef SD4_UNPACK_DAZ_EN
      f = 4'b1000; sig = 0; e = 0;
`else
      f = 4'b0100; e = 1;
      while (sig < 1024) begin
        sig = sig * 2;
        e   = e - 1;
      end
`endif
    end else begin
      f   = 4'b0000;
      sig = sig + 1024;
    end
    eb = e;
    sb = sig;
    return {s, f, eb[6:0], sb[10:0]};
  endfunction

  // Scoreboard/monitor, sampled mid-cycle: records the transfers that the
  // coming rising edge will perform.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) chk("stall_stable", pack_out(), held);
      held_v = out_valid && !out_ready;
      held   = pack_out();
      if (out_valid && out_ready) begin
        chk("outstanding", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("decode", pack_out(), exp_q.pop_front());
        emit_log.push_back(exp_out);
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    logic [15:0] w;
    rst = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_outputs", pack_out(), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;

    // Latency of a single normal word.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2);
    drain();

    // Subnormals, zeros, inf, NaN.
    send(16'h0001); send(16'h0200); send(16'h83FF);
    send(16'h8000); send(16'h7C00); send(16'hFE00);
    send(16'h0000); send(16'h7BFF);
    drain();

    // Backpressure: two accepts fill the pipe, the third word waits.
    emit_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    in_data = 16'h4000;
    tick();
    in_data = 16'h4200;
    chk("bp_in_ready_low", in_ready, 0);
    repeat (3) tick();
    chk("bp_still_blocked", in_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_count", emit_log.size(), 3);
    if (emit_log.size() == 3) begin
      chk("bp_exp0", emit_log[0], 15);
      chk("bp_exp1", emit_log[1], 16);
      chk("bp_exp2", emit_log[2], 16);
    end
    drain();

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hC500;
    tick();
    in_data = 16'h7E01;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_outputs", pack_out(), 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h4500;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("post_rst_latency", lat, 2);
    drain();

    // Randomised traffic with class-biased words.
    for (int i = 0; i < 3000; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: w[14:10] = 5'd0;
        1: w[14:10] = 5'd31;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[9:0] = 10'd0;
      in_data   = w;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
